decode_hazard_ctrl: RTL and testbench

- Pipelined successor to the combinational RV32 decode controller. Decodes the ID-stage instruction into the same control-signal set and registers it into an ID/EX control register.
- Also performs load-use hazard detection and bubble insertion, multi-cycle M-extension (MUL/DIV) occupancy with front-end stall, and flush on control-flow redirect.
- Sits between the IF/ID register and the EX datapath.

---
 rtl/decode_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_decode_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// decode_hazard_ctrl
//   RV32IM decode controller with a registered ID/EX control stage.
//   Decodes the ID-stage instruction, registers the control set into EX,
//   detects load-use hazards (one-cycle bubble), holds EX while a multi-cycle
//   MUL/DIV occupies it, and squashes ID/EX on a control-flow redirect.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   id_valid, id_instr  live instruction in IF/ID
//   flush               redirect from EX; kills ID and EX
//   stall               hold PC and IF/ID this cycle (combinational)
//   m_busy              EX holds an M op not in its final cycle (combinational)
//   ex_*                registered EX control set
// ---------------------------------------------------------------------------
module decode_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic        flush,
  output logic        stall,
  output logic        m_busy,
  output logic        ex_valid,
  output logic        ex_regesterW,
  output logic [1:0]  ex_RegSrc,
  output logic        ex_memRead,
  output logic        ex_memWrite,
  output logic [3:0]  ex_aluSelect,
  output logic [1:0]  ex_Alu2opn,
  output logic [1:0]  ex_jumpSel,
  output logic        ex_jumpOpn,
  output logic        ex_AluMulSel,
  output logic [2:0]  ex_InstFormat,
  output logic [1:0]  ex_WL,
  output logic        ex_extendSign,
  output logic [4:0]  ex_rd,
  output logic        ex_illegal
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_ALU   = 2'd0,
    SRC_MEM   = 2'd1,
    SRC_PCIMM = 2'd2,
    SRC_PC4   = 2'd3
  } regsrc_e;

  typedef enum logic [1:0] {
    PAluRb  = 2'd0,
    PAluImm = 2'd1,
    PAluPC  = 2'd2
  } alu2_e;

  typedef enum logic [1:0] {
    PJumpImm = 2'd0,
    PJumpAlu = 2'd1
  } jsel_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd8,
    ALU_EQL   = 4'd9,
    ALU_LT    = 4'd10,
    ALU_LTU   = 4'd11,
    ALU_SRA   = 4'd13,
    ALU_PASSB = 4'd15
  } aluop_e;

  typedef struct packed {
    logic       valid;
    logic       regW;
    logic [1:0] regsrc;
    logic       memRead;
    logic       memWrite;
    logic [3:0] alu;
    logic [1:0] alu2;
    logic [1:0] jsel;
    logic       jopn;
    logic       mul;
    logic [2:0] fmt;
    logic [1:0] wl;
    logic       ext;
    logic [4:0] rd;
    logic       illegal;
  } ex_ctrl_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = id_instr[6:0];
  assign rd     = id_instr[11:7];
  assign func3  = id_instr[14:12];
  assign rs1    = id_instr[19:15];
  assign rs2    = id_instr[24:20];
  assign func7  = id_instr[31:25];

  ex_ctrl_t ex_q, ex_d, dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic use_rs1, use_rs2, load_use, m_hold;

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.rd    = rd;
    dec.wl    = func3[1:0];
    dec.ext   = ~func3[2];
    use_rs1   = 1'b1;
    use_rs2   = 1'b0;
    unique case (opcode_e'(opcode))
      OP_LUI: begin
        dec.regW   = 1'b1;
        dec.regsrc = SRC_ALU;
        dec.alu    = ALU_PASSB;
        dec.alu2   = PAluImm;
        dec.fmt    = FMT_U;
        use_rs1    = 1'b0;
      end
      OP_AUIPC: begin
        dec.regW   = 1'b1;
        dec.regsrc = SRC_PCIMM;
        dec.alu    = ALU_ADD;
        dec.alu2   = PAluPC;
        dec.fmt    = FMT_U;
        use_rs1    = 1'b0;
      end
      OP_JAL: begin
        dec.regW   = 1'b1;
        dec.regsrc = SRC_PC4;
        dec.jopn   = 1'b1;
        dec.jsel   = PJumpImm;
        dec.fmt    = FMT_J;
        use_rs1    = 1'b0;
      end
      OP_JALR: begin
        dec.regW   = 1'b1;
        dec.regsrc = SRC_PC4;
        dec.jopn   = 1'b1;
        dec.jsel   = PJumpAlu;
        dec.alu    = ALU_ADD;
        dec.alu2   = PAluImm;
        dec.fmt    = FMT_I;
      end
      OP_BRANCH: begin
        dec.jsel = PJumpImm;
        dec.alu2 = PAluRb;
        dec.fmt  = FMT_B;
        use_rs2  = 1'b1;
        // func3[2:1]: 00 EQ/NE, 10 LT/GE, 11 LTU/GEU
        unique case (func3[2:1])
          2'b10:   dec.alu = ALU_LT;
          2'b11:   dec.alu = ALU_LTU;
          default: dec.alu = ALU_EQL;
        endcase
      end
      OP_LOAD: begin
        dec.regW    = 1'b1;
        dec.memRead = 1'b1;
        dec.regsrc  = SRC_MEM;
        dec.alu     = ALU_ADD;
        dec.alu2    = PAluImm;
        dec.fmt     = FMT_I;
      end
      OP_STORE: begin
        dec.memWrite = 1'b1;
        dec.alu      = ALU_ADD;
        dec.alu2     = PAluImm;
        dec.fmt      = FMT_S;
        use_rs2      = 1'b1;
      end
      OP_IMM: begin
        dec.regW = 1'b1;
        dec.alu2 = PAluImm;
        dec.fmt  = FMT_I;
        if (func3 == 3'b101 && func7[5]) dec.alu = ALU_SRA;
        else                              dec.alu = {1'b0, func3};
      end
      OP_REG: begin
        dec.regW = 1'b1;
        dec.alu2 = PAluRb;
        dec.fmt  = FMT_R;
        use_rs2  = 1'b1;
        if (func7 == 7'b0000001) begin
          dec.mul = 1'b1;
          dec.alu = {1'b0, func3};
        end else if (func3 == 3'b000 && func7[5]) begin
          dec.alu = ALU_SUB;
        end else if (func3 == 3'b101 && func7[5]) begin
          dec.alu = ALU_SRA;
        end else begin
          dec.alu = {1'b0, func3};
        end
      end
      default: begin
        // Unknown opcode travels down as a marked, side-effect-free slot
        dec.illegal = 1'b1;
        dec.wl      = '0;
        dec.ext     = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Hazards and stall
  // -------------------------------------------------------------------------
  assign m_hold = (cnt_q != '0);
  assign m_busy = m_hold;

  // An M op in EX is never a load, so the load-use test is naturally off
  // during the hold.
  assign load_use = ex_q.valid && ex_q.memRead && (ex_q.rd != '0) && id_valid &&
                    ((use_rs1 && (rs1 == ex_q.rd)) || (use_rs2 && (rs2 == ex_q.rd)));

  assign stall = !flush && (m_hold || load_use);

  // -------------------------------------------------------------------------
  // ID/EX register
  // -------------------------------------------------------------------------
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (flush) begin
      ex_d  = '0;
      cnt_d = '0;
    end else if (m_hold) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (load_use) begin
      ex_d = '0;
    end else if (id_valid) begin
      ex_d = dec;
      if (dec.mul) cnt_d = func3[2] ? DIV_LD : MUL_LD;
      else         cnt_d = '0;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_regesterW  = ex_q.regW;
  assign ex_RegSrc     = ex_q.regsrc;
  assign ex_memRead    = ex_q.memRead;
  assign ex_memWrite   = ex_q.memWrite;
  assign ex_aluSelect  = ex_q.alu;
  assign ex_Alu2opn    = ex_q.alu2;
  assign ex_jumpSel    = ex_q.jsel;
  assign ex_jumpOpn    = ex_q.jopn;
  assign ex_AluMulSel  = ex_q.mul;
  assign ex_InstFormat = ex_q.fmt;
  assign ex_WL         = ex_q.wl;
  assign ex_extendSign = ex_q.ext;
  assign ex_rd         = ex_q.rd;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        flush;
  logic        stall, m_busy, ex_valid, ex_regesterW;
  logic [1:0]  ex_RegSrc;
  logic        ex_memRead, ex_memWrite;
  logic [3:0]  ex_aluSelect;
  logic [1:0]  ex_Alu2opn, ex_jumpSel;
  logic        ex_jumpOpn, ex_AluMulSel;
  logic [2:0]  ex_InstFormat;
  logic [1:0]  ex_WL;
  logic        ex_extendSign;
  logic [4:0]  ex_rd;
  logic        ex_illegal;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  localparam logic [31:0] I_ADDI_X1   = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] I_LW_X2     = 32'h0000_A103; // lw   x2,0(x1)
  localparam logic [31:0] I_LW_X0     = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD_321   = 32'h0011_01B3; // add  x3,x2,x1
  localparam logic [31:0] I_ADD_312   = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_ADD_301   = 32'h0010_01B3; // add  x3,x0,x1
  localparam logic [31:0] I_ADD_345   = 32'h0052_01B3; // add  x3,x4,x5
  localparam logic [31:0] I_ADDI_312  = 32'h0020_8193; // addi x3,x1,2
  localparam logic [31:0] I_LUI_X3    = 32'h0001_01B7; // lui  x3,0x10
  localparam logic [31:0] I_MUL       = 32'h0220_8333; // mul  x6,x1,x2
  localparam logic [31:0] I_DIV       = 32'h0220_C3B3; // div  x7,x1,x2
  localparam logic [31:0] I_AUIPC     = 32'h0000_1297; // auipc x5,1
  localparam logic [31:0] I_JALR      = 32'h0002_80E7; // jalr x1,0(x5)
  localparam logic [31:0] I_SUB       = 32'h4020_81B3; // sub  x3,x1,x2
  localparam logic [31:0] I_BLT       = 32'h0020_C063; // blt  x1,x2,0
  localparam logic [31:0] I_BAD       = 32'h0000_007F;

  decode_hazard_ctrl #(
    .MUL_CYCLES(3),
    .DIV_CYCLES(33),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .flush(flush),
    .stall(stall),
    .m_busy(m_busy),
    .ex_valid(ex_valid),
    .ex_regesterW(ex_regesterW),
    .ex_RegSrc(ex_RegSrc),
    .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite),
    .ex_aluSelect(ex_aluSelect),
    .ex_Alu2opn(ex_Alu2opn),
    .ex_jumpSel(ex_jumpSel),
    .ex_jumpOpn(ex_jumpOpn),
    .ex_AluMulSel(ex_AluMulSel),
    .ex_InstFormat(ex_InstFormat),
    .ex_WL(ex_WL),
    .ex_extendSign(ex_extendSign),
    .ex_rd(ex_rd),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins);
    id_valid = v;
    id_instr = ins;
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, '0);
    step();
    step();

    // Reset state
    check("rst_valid", ex_valid, 0);
    check("rst_regW", ex_regesterW, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_stall", stall, 0);
    check("rst_mbusy", m_busy, 0);

    // ADDI x1,x0,5
    rst_n = 1'b1;
    drive(1'b1, I_ADDI_X1);
    settle();
    check("addi_stall", stall, 0);
    step();
    check("addi_valid", ex_valid, 1);
    check("addi_regW", ex_regesterW, 1);
    check("addi_alu", ex_aluSelect, 0);
    check("addi_alu2", ex_Alu2opn, 1);
    check("addi_rd", ex_rd, 1);
    check("addi_src", ex_RegSrc, 0);

    // LW x2 then ADD x3,x2,x1: one bubble
    drive(1'b1, I_LW_X2);
    step();
    check("lw_memRead", ex_memRead, 1);
    check("lw_src", ex_RegSrc, 1);
    check("lw_wl", ex_WL, 2);
    check("lw_ext", ex_extendSign, 1);
    check("lw_rd", ex_rd, 2);
    drive(1'b1, I_ADD_321);
    settle();
    check("lu_rs1_stall", stall, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_memRead", ex_memRead, 0);
    check("lu_bubble_regW", ex_regesterW, 0);
    check("lu_release", stall, 0);
    step();
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 3);
    check("lu_add_alu2", ex_Alu2opn, 0);

    // Hazard via rs2
    drive(1'b1, I_LW_X2);
    step();
    drive(1'b1, I_ADD_312);
    settle();
    check("lu_rs2_stall", stall, 1);
    step();
    check("lu_rs2_bubble", ex_valid, 0);
    step();
    check("lu_rs2_add_rd", ex_rd, 3);

    // x0 load destination never stalls
    drive(1'b1, I_LW_X0);
    step();
    check("lwx0_rd", ex_rd, 0);
    drive(1'b1, I_ADD_301);
    settle();
    check("lu_x0_stall", stall, 0);
    step();
    check("lu_x0_add_valid", ex_valid, 1);
    check("lu_x0_add_rd", ex_rd, 3);

    // Unrelated sources, imm bits in rs2 slot, LUI with rs1 slot bits
    drive(1'b1, I_LW_X2);
    step();
    drive(1'b1, I_ADD_345);
    settle();
    check("lu_none_stall", stall, 0);
    drive(1'b1, I_ADDI_312);
    settle();
    check("lu_imm_stall", stall, 0);
    drive(1'b1, I_LUI_X3);
    settle();
    check("lu_lui_stall", stall, 0);
    step();
    check("lui_regW", ex_regesterW, 1);
    check("lui_alu", ex_aluSelect, 15);
    check("lui_alu2", ex_Alu2opn, 1);
    check("lui_fmt", ex_InstFormat, 4);

    // MUL, 3 cycles
    drive(1'b1, I_MUL);
    step();
    check("mul_c1_sel", ex_AluMulSel, 1);
    check("mul_c1_busy", m_busy, 1);
    check("mul_c1_stall", stall, 1);
    check("mul_c1_rd", ex_rd, 6);
    drive(1'b1, I_ADDI_X1);
    step();
    check("mul_c2_sel", ex_AluMulSel, 1);
    check("mul_c2_busy", m_busy, 1);
    check("mul_c2_stall", stall, 1);
    step();
    check("mul_c3_sel", ex_AluMulSel, 1);
    check("mul_c3_busy", m_busy, 0);
    check("mul_c3_stall", stall, 0);
    step();
    check("mul_next_sel", ex_AluMulSel, 0);
    check("mul_next_rd", ex_rd, 1);

    // DIV, 33 cycles -> 32 stalled
    drive(1'b1, I_DIV);
    step();
    check("div_sel", ex_AluMulSel, 1);
    check("div_alu", ex_aluSelect, 4);
    drive(1'b1, I_ADDI_X1);
    n = 0;
    while (stall && n < 100) begin
      n++;
      step();
    end
    check("div_stall_cycles", n, 32);
    check("div_last_sel", ex_AluMulSel, 1);
    check("div_last_rd", ex_rd, 7);
    step();
    check("div_next_rd", ex_rd, 1);

    // Flush in DIV cycle 5
    drive(1'b1, I_DIV);
    step();
    drive(1'b1, I_ADDI_X1);
    for (int i = 0; i < 4; i++) step();
    check("fl_busy_before", m_busy, 1);
    flush = 1'b1;
    settle();
    check("fl_stall_in_flush", stall, 0);
    step();
    flush = 1'b0;
    drive(1'b0, '0);
    settle();
    check("fl_valid", ex_valid, 0);
    check("fl_busy", m_busy, 0);
    check("fl_stall", stall, 0);
    check("fl_sel", ex_AluMulSel, 0);

    // Assorted decodes
    drive(1'b1, I_AUIPC);
    step();
    check("auipc_src", ex_RegSrc, 2);
    check("auipc_alu", ex_aluSelect, 0);
    check("auipc_alu2", ex_Alu2opn, 2);
    drive(1'b1, I_JALR);
    step();
    check("jalr_opn", ex_jumpOpn, 1);
    check("jalr_sel", ex_jumpSel, 1);
    check("jalr_src", ex_RegSrc, 3);
    check("jalr_regW", ex_regesterW, 1);
    drive(1'b1, I_SUB);
    step();
    check("sub_alu", ex_aluSelect, 8);
    drive(1'b1, I_BLT);
    step();
    check("blt_alu", ex_aluSelect, 10);
    check("blt_regW", ex_regesterW, 0);
    check("blt_fmt", ex_InstFormat, 3);
    drive(1'b1, I_BAD);
    step();
    check("bad_valid", ex_valid, 1);
    check("bad_illegal", ex_illegal, 1);
    check("bad_regW", ex_regesterW, 0);
    check("bad_memRead", ex_memRead, 0);
    check("bad_memWrite", ex_memWrite, 0);

    // Reset mid-DIV
    drive(1'b1, I_DIV);
    step();
    drive(1'b0, '0);
    step();
    step();
    check("rd_busy_before", m_busy, 1);
    rst_n = 1'b0;
    step();
    check("rmid_valid", ex_valid, 0);
    check("rmid_sel", ex_AluMulSel, 0);
    check("rmid_alu", ex_aluSelect, 0);
    check("rmid_rd", ex_rd, 0);
    check("rmid_busy", m_busy, 0);
    check("rmid_stall", stall, 0);
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
